// File: rtl/led_pattern_counter.sv
// Purpose: LED bank pattern counter (binary up/down, Gray, bouncing scan) with run/pause and mode buttons.
// Latency: a button press updates the registered outputs DEBOUNCE_CYCLES+5 edges after btn is first sampled high.
// Backpressure: none; the outputs drive pins directly and every tick is consumed when it fires.
//
// Ports:
//   CLK  - system clock, FREQ Hz
//   RS   - asynchronous active-high reset
//   btn  - raw active-high buttons, asynchronous to CLK; [0] run/pause, [1] mode advance
//   led  - registered pattern output, active-high
//   rgb  - registered mode indicator, active-low {B,G,R}; all off while paused
module led_pattern_counter #(
  parameter int FREQ            = 12000000,
  parameter int TICK_HZ         = 1,
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic             CLK,
  input  logic             RS,
  input  logic [1:0]       btn,
  output logic [WIDTH-1:0] led,
  output logic [2:0]       rgb
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int PERIOD = FREQ / TICK_HZ;
  localparam int PS_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PERIOD - 1);
  localparam logic [PS_W-1:0]  PS_ONE    = PS_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
  // In scan mode, stepping left from this position lands on the top bit.
  localparam logic [WIDTH-1:0] SCAN_TURN = WIDTH'(WIDTH - 2);

  typedef enum logic [1:0] {
    MODE_BIN_UP   = 2'd0,
    MODE_BIN_DOWN = 2'd1,
    MODE_GRAY     = 2'd2,
    MODE_SCAN     = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // ---------------------------------------------------------------------------
  // Button path: 2-flop synchroniser, debounce counter, rising-edge pulse
  // ---------------------------------------------------------------------------
  logic [1:0]      sync_meta;
  logic [1:0]      sync_q;
  logic [1:0]      db_level;
  logic [1:0]      db_level_d;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  always_ff @(posedge CLK or posedge RS) begin
    if (RS) begin
      sync_meta  <= '0;
      sync_q     <= '0;
      db_level   <= '0;
      db_level_d <= '0;
      press      <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_meta  <= btn;
      sync_q     <= sync_meta;
      db_level_d <= db_level;
      // Release produces no event; only the debounced 0->1 transition pulses.
      press      <= db_level & ~db_level_d;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] != db_level[i]) begin
          // The count reaching DB_LAST means this is the Nth consecutive
          // differing cycle, so the new level is accepted now.
          if (db_cnt[i] == DB_LAST) begin
            db_level[i] <= sync_q[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_ONE;
          end
        end else begin
          // Any return to the accepted level restarts the stability window.
          db_cnt[i] <= '0;
        end
      end
    end
  end

  logic run_press;
  logic mode_press;

  assign run_press  = press[0];
  assign mode_press = press[1];

  // ---------------------------------------------------------------------------
  // Pattern core: state register
  // ---------------------------------------------------------------------------
  logic             running, running_nx;
  mode_e            mode, mode_nx;
  logic [PS_W-1:0]  ps, ps_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  dir_e             dir, dir_nx;
  logic [WIDTH-1:0] led_q, led_nx;
  logic [2:0]       rgb_q, rgb_nx;
  logic             tick;

  always_ff @(posedge CLK or posedge RS) begin
    if (RS) begin
      running <= 1'b1;
      mode    <= MODE_BIN_UP;
      ps      <= '0;
      cnt     <= '0;
      dir     <= DIR_LEFT;
      led_q   <= '0;
      rgb_q   <= 3'b110;
    end else begin
      running <= running_nx;
      mode    <= mode_nx;
      ps      <= ps_nx;
      cnt     <= cnt_nx;
      dir     <= dir_nx;
      led_q   <= led_nx;
      rgb_q   <= rgb_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern core: next state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    running_nx = running;
    mode_nx    = mode;
    ps_nx      = ps;
    cnt_nx     = cnt;
    dir_nx     = dir;
    led_nx     = '0;
    rgb_nx     = 3'b111;

    // Tick fires on the wrap cycle; a paused prescaler holds so resuming
    // continues the interrupted period rather than starting a new one.
    tick = running && (ps == PS_LAST);

    if (running) begin
      ps_nx = tick ? '0 : ps + PS_ONE;
    end

    if (tick) begin
      case (mode)
        MODE_BIN_UP,
        MODE_GRAY:     cnt_nx = cnt + CNT_ONE;
        MODE_BIN_DOWN: cnt_nx = cnt - CNT_ONE;
        MODE_SCAN: begin
          // Direction flips on arrival at an end so each end bit shows
          // for exactly one tick.
          if (dir == DIR_LEFT) begin
            cnt_nx = cnt + CNT_ONE;
            if (cnt == SCAN_TURN) begin
              dir_nx = DIR_RIGHT;
            end
          end else begin
            cnt_nx = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              dir_nx = DIR_LEFT;
            end
          end
        end
        default: cnt_nx = cnt;
      endcase
    end

    if (run_press) begin
      running_nx = ~running;
    end

    // Mode advance restarts the pattern and the tick period; it overrides any
    // step computed above, so a coincident tick is dropped.
    if (mode_press) begin
      mode_nx = mode_e'(2'(mode) + 2'd1);
      ps_nx   = '0;
      cnt_nx  = '0;
      dir_nx  = DIR_LEFT;
    end

    // Outputs are decoded from the current state and registered, so they
    // follow a state change by one edge and have no path from btn.
    case (mode)
      MODE_BIN_UP,
      MODE_BIN_DOWN: led_nx = cnt;
      MODE_GRAY:     led_nx = cnt ^ (cnt >> 1);
      MODE_SCAN:     led_nx = CNT_ONE << cnt;
      default:       led_nx = cnt;
    endcase

    if (running) begin
      case (mode)
        MODE_BIN_UP:   rgb_nx = 3'b110;
        MODE_BIN_DOWN: rgb_nx = 3'b101;
        MODE_GRAY:     rgb_nx = 3'b011;
        MODE_SCAN:     rgb_nx = 3'b000;
        default:       rgb_nx = 3'b111;
      endcase
    end
  end

  assign led = led_q;
  assign rgb = rgb_q;

endmodule

// File: tb/tb_led_pattern_counter.sv
// Bench for led_pattern_counter with a 10-cycle tick and a 4-cycle debounce.
// Expected led/rgb changes (value and edge number) are queued when stimulus
// is applied and popped by a monitor whenever the DUT outputs change.
module tb_led_pattern_counter;

  logic       CLK;
  logic       RS;
  logic [1:0] btn;
  logic [3:0] led;
  logic [2:0] rgb;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] val;
    int         at;
  } ev_t;

  ev_t led_q[$];
  ev_t rgb_q[$];

  logic [3:0] prev_led;
  logic [2:0] prev_rgb;
  logic [3:0] last_led_exp;
  logic [2:0] last_rgb_exp;

  // Spec-level view of the counter: current mode, edge on which step 0 was
  // shown, next step index to schedule, run state and the pause edge.
  int cur_mode;
  int s_edge;
  int k_next;
  int p_edge;
  bit run_st;

  led_pattern_counter #(
    .FREQ(20),
    .TICK_HZ(2),
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .RS(RS),
    .btn(btn),
    .led(led),
    .rgb(rgb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h edge=%0d", tag, got, exp, cyc);
    end
  endtask

  // Expected led after k steps from a fresh mode start.
  function automatic logic [3:0] pat(input int m, input int k);
    logic [3:0] g;
    case (m)
      0: return 4'(k % 16);
      1: return 4'((16 - (k % 16)) % 16);
      2: begin
        g = 4'(k % 16);
        return g ^ (g >> 1);
      end
      default: begin
        case (k % 6)
          0: return 4'd1;
          1: return 4'd2;
          2: return 4'd4;
          3: return 4'd8;
          4: return 4'd4;
          default: return 4'd2;
        endcase
      end
    endcase
  endfunction

  function automatic logic [2:0] color(input int m);
    case (m)
      0: return 3'b110;
      1: return 3'b101;
      2: return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push_led(input logic [3:0] v, input int t);
    if (v !== last_led_exp) begin
      led_q.push_back('{v, t});
      last_led_exp = v;
    end
  endtask

  task automatic push_rgb(input logic [2:0] v, input int t);
    if (v !== last_rgb_exp) begin
      rgb_q.push_back('{{1'b0, v}, t});
      last_rgb_exp = v;
    end
  endtask

  // Schedule every pattern step whose led update lands on or before edge e.
  task automatic push_through(input int e);
    if (run_st) begin
      while (s_edge + 10 * k_next <= e) begin
        push_led(pat(cur_mode, k_next), s_edge + 10 * k_next);
        k_next++;
      end
    end
  endtask

  task automatic run_to(input int e);
    push_through(e);
    while (cyc < e) @(negedge CLK);
  endtask

  // Clean 6-cycle press. The register it controls updates on edge n+8 and the
  // outputs follow on edge n+9.
  task automatic press(input int b);
    int n;
    int m;
    n = cyc;
    m = n + 8;
    if (b == 1) begin
      push_through(m);
      cur_mode = (cur_mode + 1) % 4;
      s_edge   = m + 1;
      k_next   = 1;
      push_led(pat(cur_mode, 0), m + 1);
      if (run_st) push_rgb(color(cur_mode), m + 1);
    end else if (run_st) begin
      push_through(m + 1);
      run_st = 1'b0;
      p_edge = m;
      push_rgb(3'b111, m + 1);
    end else begin
      s_edge = s_edge + (m - p_edge);
      run_st = 1'b1;
      push_rgb(color(cur_mode), m + 1);
    end
    btn[b] = 1'b1;
    repeat (6) @(negedge CLK);
    btn[b] = 1'b0;
  endtask

  always @(negedge CLK) begin
    ev_t e;
    if (RS) begin
      prev_led = led;
      prev_rgb = rgb;
    end else begin
      if (led !== prev_led) begin
        if (led_q.size() == 0) begin
          chk("led_extra", 32'(led), 32'(prev_led));
        end else begin
          e = led_q.pop_front();
          chk("led_val", 32'(led), 32'(e.val));
          chk("led_edge", 32'(cyc), 32'(e.at));
        end
        prev_led = led;
      end
      if (rgb !== prev_rgb) begin
        if (rgb_q.size() == 0) begin
          chk("rgb_extra", 32'(rgb), 32'(prev_rgb));
        end else begin
          e = rgb_q.pop_front();
          chk("rgb_val", 32'({1'b0, rgb}), 32'(e.val));
          chk("rgb_edge", 32'(cyc), 32'(e.at));
        end
        prev_rgb = rgb;
      end
    end
  end

  initial begin
    int tk;
    RS           = 1'b1;
    btn          = 2'b00;
    last_led_exp = 4'd0;
    last_rgb_exp = 3'b110;
    cur_mode     = 0;
    run_st       = 1'b1;
    k_next       = 1;
    p_edge       = 0;
    s_edge       = 0;

    repeat (3) @(negedge CLK);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'b110);
    RS     = 1'b0;
    s_edge = cyc + 1;

    // Free-running binary up count, full wrap.
    run_to(cyc + 170);

    // Mode advance to binary down.
    press(1);
    run_to(cyc + 60);

    // Bouncy run button must not toggle the run state.
    push_through(cyc + 40);
    btn[0] = 1'b1;
    repeat (3) @(negedge CLK);
    btn[0] = 1'b0;
    @(negedge CLK);
    btn[0] = 1'b1;
    repeat (2) @(negedge CLK);
    btn[0] = 1'b0;
    run_to(cyc + 20);

    // Pause, hold for 100 cycles, resume on the held prescaler count.
    press(0);
    run_to(cyc + 100);
    press(0);
    run_to(cyc + 60);

    // Gray then scan, eight ticks each.
    press(1);
    run_to(s_edge + 85);
    press(1);
    run_to(s_edge + 85);

    // Mode press landing on a tick edge: tick dropped, restart from 0.
    tk = s_edge - 1 + 10 * k_next;
    while (tk - 8 <= cyc) tk = tk + 10;
    run_to(tk - 8);
    press(1);
    run_to(cyc + 40);

    // Back to scan, pause, then async reset between clock edges.
    press(1);
    run_to(cyc + 15);
    press(1);
    run_to(cyc + 15);
    press(1);
    run_to(cyc + 25);
    press(0);
    run_to(cyc + 25);

    @(negedge CLK);
    #2 RS = 1'b1;
    #1;
    chk("arst_led", 32'(led), 32'd0);
    chk("arst_rgb", 32'(rgb), 32'b110);
    last_led_exp = 4'd0;
    last_rgb_exp = 3'b110;
    cur_mode     = 0;
    run_st       = 1'b1;
    k_next       = 1;
    repeat (2) @(negedge CLK);
    RS     = 1'b0;
    s_edge = cyc + 1;
    run_to(cyc + 45);

    chk("led_q_left", 32'(led_q.size()), 32'd0);
    chk("rgb_q_left", 32'(rgb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_counter.md
Name: led_pattern_counter

Overview:
- Parametrised successor of the board-level LED counter.
- Drives a WIDTH-bit LED bank from an internal tick prescaler (FREQ/TICK_HZ). Four selectable count patterns: binary up, binary down, Gray, bouncing scan.
- Two debounced push-buttons: one toggles run/pause, one advances the pattern mode. Active-low RGB LED shows the current mode.
- Sits at the top of the CMOD S7 demo designs, directly between board pins and LEDs.

Parameters:
FREQ, 12000000, CLK frequency in Hz
TICK_HZ, 1, pattern steps per second; FREQ/TICK_HZ must be an integer >= 2
WIDTH, 4, LED bank width, 2..16
DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a button level change (>= 1)

Ports:
CLK  input  1  system clock, FREQ Hz
RS  input  1  reset, asynchronous, active-high
btn  input  2  raw push-buttons, active-high, asynchronous to CLK; btn[0]=run/pause, btn[1]=mode advance
led  output  WIDTH  pattern output, active-high
rgb  output  3  mode indicator, active-low {B,G,R}

Behaviour:
- Reset (RS high, async): running=1, mode=0, prescaler=0, internal count=0, scan dir=left, debouncers at 0.
  - Outputs during and after reset: led=0, rgb=3'b110 (red on).
- Button path, per bit:
  - 2-flop synchroniser, then debounce counter.
  - Debounced level flips only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce clears the counter.
  - The debounced rising edge produces a 1-cycle press pulse. There is no event on release.
  - Latency: the press pulse is high on exactly the (DEBOUNCE_CYCLES+3)th rising CLK edge after btn is first sampled high.
  - The affected register (running or mode) updates on the following edge.
- Prescaler: counts 0..FREQ/TICK_HZ-1 while running, then wraps. The 1-cycle tick pulse fires on the wrap cycle.
  - Paused: prescaler holds its value and no ticks occur. Resuming continues from the held value.
- Run press: running <= ~running.
- Mode press: mode <= mode+1 mod 4. In the same cycle: prescaler <= 0, internal count <= 0, scan dir <= left.
  - Mode press has priority over a coincident tick; that tick is discarded.
  - The running state is unaffected.
- Both presses in the same cycle: both take effect.
- Pattern step on each tick:
  - Mode 0 BIN_UP: cnt <= cnt+1, wraps all-ones -> 0. led = cnt.
  - Mode 1 BIN_DOWN: cnt <= cnt-1, wraps 0 -> all-ones. led = cnt.
  - Mode 2 GRAY: cnt increments as in mode 0. led = cnt ^ (cnt >> 1).
  - Mode 3 SCAN: led is one-hot = 1 << cnt. cnt starts at 0 with dir=left.
    - dir=left: cnt++. On reaching WIDTH-1, dir flips to right.
    - dir=right: cnt--. On reaching 0, dir flips to left.
    - The end bit is shown for one tick only (sequence for WIDTH=4: 1,2,4,8,4,2,1,2,...).
- led and rgb are registered and update on the edge after the state change. No combinational path from btn to outputs.
- rgb mapping:
  - Running: mode0=3'b110 (R), mode1=3'b101 (G), mode2=3'b011 (B), mode3=3'b000 (white).
  - Paused: rgb=3'b111 (all off). led holds its last value.
- RS asserted mid-operation: everything returns to reset values immediately. The first tick after release occurs FREQ/TICK_HZ cycles after the first post-reset edge.

Test Plan:
(Bench params: FREQ=20, TICK_HZ=2 giving a 10-cycle tick period, WIDTH=4, DEBOUNCE_CYCLES=4.)
1. Release RS, no buttons, run 170 cycles -> led steps 0,1,...,15,0 every 10 cycles; rgb=3'b110 throughout.
2. Hold btn[1] clean high -> press pulse on edge 7, mode=1 on edge 8, led=0, rgb=3'b101. Then led sequence 15,14,13... every 10 cycles.
3. Bounce btn[0] as high 3 cycles, low 1, high 2, then low -> no press pulse, running stays 1. A clean 6-cycle high -> pause: rgb=3'b111, led frozen for 100 cycles. Second press -> resumes at the held value on the remaining prescaler count.
4. Advance to mode 2, run 8 ticks -> led=0,1,3,2,6,7,5,4,12. Advance to mode 3, run 8 ticks -> led=1,2,4,8,4,2,1,2,4.
5. Mode press on the same edge as a tick -> no step that cycle; led=0 (or 1 in mode 3); next step 10 cycles later.
6. Assert RS asynchronously mid-tick in mode 3 while paused -> led=0, rgb=3'b110 before the next CLK edge. After release, running and stepping resume in mode 0.
